// File: rtl/alu_operand_stage_if.sv
// Bundle of handshake, operand and forwarding signals for the Execute-stage
// operand selector. The upstream/bench side uses the master modport and the
// operand stage itself uses the slave modport.
interface alu_operand_stage_if #(
    parameter int XLEN       = 32,
    parameter int NUM_FWD    = 2,
    parameter int REG_ADDR_W = 5
) ();

    logic                          inValid;
    logic                          inReady;
    logic [REG_ADDR_W-1:0]         rs1Addr;
    logic [REG_ADDR_W-1:0]         rs2Addr;
    logic [XLEN-1:0]               rs1Data;
    logic [XLEN-1:0]               rs2Data;
    logic [XLEN-1:0]               pcValue;
    logic [XLEN-1:0]               immediateValue;
    logic [1:0]                    input1Select;
    logic [2:0]                    input2Select;
    logic                          storeEnable;
    logic [NUM_FWD-1:0]            fwdEnable;
    logic [NUM_FWD*REG_ADDR_W-1:0] fwdRd;
    logic [NUM_FWD*XLEN-1:0]       fwdData;
    logic [NUM_FWD-1:0]            fwdDataReady;
    logic                          flush;
    logic                          outValid;
    logic                          outReady;
    logic [XLEN-1:0]               input1Alu;
    logic [XLEN-1:0]               input2Alu;
    logic [XLEN-1:0]               storeData;
    logic                          hazardStall;

    modport master (
        output inValid, rs1Addr, rs2Addr, rs1Data, rs2Data, pcValue,
               immediateValue, input1Select, input2Select, storeEnable,
               fwdEnable, fwdRd, fwdData, fwdDataReady, flush, outReady,
        input  inReady, outValid, input1Alu, input2Alu, storeData, hazardStall
    );

    modport slave (
        input  inValid, rs1Addr, rs2Addr, rs1Data, rs2Data, pcValue,
               immediateValue, input1Select, input2Select, storeEnable,
               fwdEnable, fwdRd, fwdData, fwdDataReady, flush, outReady,
        output inReady, outValid, input1Alu, input2Alu, storeData, hazardStall
    );

endinterface

// File: rtl/alu_operand_stage.sv
// Execute-stage operand selector and pipeline register.
// Both ALU operands are resolved through a prioritised forwarding network
// (source 0 is the youngest and wins), load-use hazards hold the bundle
// upstream, and the chosen operands are registered behind a valid/ready
// handshake that also supports flush.
module alu_operand_stage #(
    parameter int XLEN       = 32,
    parameter int NUM_FWD    = 2,
    parameter int REG_ADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    alu_operand_stage_if.slave bus
);

    logic [XLEN-1:0] w_rs1Value;
    logic [XLEN-1:0] w_rs2Value;
    logic            w_rs1Pending;
    logic            w_rs2Pending;
    logic            w_rs1Needed;
    logic            w_rs2Needed;
    logic            w_hazard;
    logic            w_inReady;
    logic            w_capture;
    logic [XLEN-1:0] w_operand1;
    logic [XLEN-1:0] w_operand2;

    logic            r_outValid;
    logic [XLEN-1:0] r_input1Alu;
    logic [XLEN-1:0] r_input2Alu;
    logic [XLEN-1:0] r_storeData;

    // Resolve rs1/rs2 through the forwarding sources; scanning from the oldest
    // source down lets the youngest match overwrite, and its ready bit alone
    // decides whether the value is still outstanding.
    always_comb begin
        w_rs1Value   = bus.rs1Data;
        w_rs2Value   = bus.rs2Data;
        w_rs1Pending = 1'b0;
        w_rs2Pending = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (bus.fwdEnable[i] &&
                (bus.fwdRd[i*REG_ADDR_W +: REG_ADDR_W] == bus.rs1Addr) &&
                (bus.rs1Addr != '0)) begin
                w_rs1Value   = bus.fwdData[i*XLEN +: XLEN];
                w_rs1Pending = ~bus.fwdDataReady[i];
            end
            if (bus.fwdEnable[i] &&
                (bus.fwdRd[i*REG_ADDR_W +: REG_ADDR_W] == bus.rs2Addr) &&
                (bus.rs2Addr != '0)) begin
                w_rs2Value   = bus.fwdData[i*XLEN +: XLEN];
                w_rs2Pending = ~bus.fwdDataReady[i];
            end
        end
        if (bus.rs1Addr == '0) begin
            w_rs1Value = '0;
        end
        if (bus.rs2Addr == '0) begin
            w_rs2Value = '0;
        end
    end

    // Only operands that the selected instruction actually consumes can stall.
    assign w_rs1Needed = (bus.input1Select == 2'b00);
    assign w_rs2Needed = (bus.input2Select == 3'b000) | bus.storeEnable;
    assign w_hazard    = (w_rs1Needed & w_rs1Pending) | (w_rs2Needed & w_rs2Pending);
    assign w_inReady   = ~w_hazard & (~r_outValid | bus.outReady);
    assign w_capture   = bus.inValid & w_inReady & ~bus.flush;

    // Pick each ALU operand from the forwarded register value, PC, immediate
    // or a zero-extended constant.
    always_comb begin
        w_operand1 = '0;
        w_operand2 = '0;
        case (bus.input1Select)
            2'b00:   w_operand1 = w_rs1Value;
            2'b01:   w_operand1 = bus.pcValue;
            default: w_operand1 = '0;
        endcase
        case (bus.input2Select)
            3'b000:  w_operand2 = w_rs2Value;
            3'b001:  w_operand2 = bus.immediateValue;
            3'b010:  w_operand2 = XLEN'(1);
            3'b011:  w_operand2 = XLEN'(4);
            default: w_operand2 = '0;
        endcase
    end

    // Output register: reset clears everything, flush kills the held bundle,
    // a capture loads (possibly replacing a draining bundle), a drain empties.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outValid  <= 1'b0;
            r_input1Alu <= '0;
            r_input2Alu <= '0;
            r_storeData <= '0;
        end else if (bus.flush) begin
            r_outValid  <= 1'b0;
        end else if (w_capture) begin
            r_outValid  <= 1'b1;
            r_input1Alu <= w_operand1;
            r_input2Alu <= w_operand2;
            r_storeData <= w_rs2Value;
        end else if (r_outValid && bus.outReady) begin
            r_outValid  <= 1'b0;
        end
    end

    assign bus.inReady     = w_inReady;
    assign bus.hazardStall = bus.inValid & w_hazard;
    assign bus.outValid    = r_outValid;
    assign bus.input1Alu   = r_input1Alu;
    assign bus.input2Alu   = r_input2Alu;
    assign bus.storeData   = r_storeData;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage. Stimulus pushes the hand-computed
// bundle into a queue when the block accepts it; a monitor pops and compares
// whenever the block hands a bundle downstream.
module tb_alu_operand_stage;

    localparam int XLEN       = 32;
    localparam int NUM_FWD    = 2;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [XLEN-1:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t expQ[$];
    exp_t monitorItem;
    int   checks = 0;
    int   errors = 0;

    alu_operand_stage_if #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_ADDR_W(REG_ADDR_W)) bus ();

    alu_operand_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic exp_t mkExp(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                   input logic [XLEN-1:0] c);
        exp_t e;
        e.in1 = a;
        e.in2 = b;
        e.st  = c;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                               input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic clearInputs();
        bus.inValid        = 1'b0;
        bus.rs1Addr        = '0;
        bus.rs2Addr        = '0;
        bus.rs1Data        = '0;
        bus.rs2Data        = '0;
        bus.pcValue        = '0;
        bus.immediateValue = '0;
        bus.input1Select   = 2'b00;
        bus.input2Select   = 3'b000;
        bus.storeEnable    = 1'b0;
        bus.fwdEnable      = '0;
        bus.fwdRd          = '0;
        bus.fwdData        = '0;
        bus.fwdDataReady   = '1;
        bus.flush          = 1'b0;
        bus.outReady       = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present the current inputs as a bundle, wait (bounded) for acceptance,
    // record the expected result, then withdraw inValid after the edge.
    task automatic applyStimulus(input exp_t e, input int maxWait);
        int n;
        n = 0;
        bus.inValid = 1'b1;
        @(negedge clk);
        while (!bus.inReady && n < maxWait) begin
            @(negedge clk);
            n++;
        end
        if (!bus.inReady) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout: actual inReady=0 after %0d cycles, required 1", n);
        end else begin
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.inValid = 1'b0;
    endtask

    // Monitor: compare every bundle handed downstream against the queue.
    always @(negedge clk) begin
        if (!reset && bus.outValid && bus.outReady) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedOutput: actual bundle in1=0x%0h, required none",
                         bus.input1Alu);
            end else begin
                monitorItem = expQ.pop_front();
                checkOutput("input1Alu", bus.input1Alu, monitorItem.in1);
                checkOutput("input2Alu", bus.input2Alu, monitorItem.in2);
                checkOutput("storeData", bus.storeData, monitorItem.st);
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        clearInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("resetOutValid", XLEN'(bus.outValid), '0);
        checkOutput("resetInput1", bus.input1Alu, '0);
        checkOutput("resetInput2", bus.input2Alu, '0);
        checkOutput("resetStore", bus.storeData, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic register/immediate selection with one-cycle latency.
        bus.rs1Addr        = 5'd1;
        bus.rs1Data        = 32'h10;
        bus.rs2Addr        = 5'd2;
        bus.rs2Data        = 32'h99;
        bus.immediateValue = 32'h5;
        bus.input1Select   = 2'b00;
        bus.input2Select   = 3'b001;
        applyStimulus(mkExp(32'h10, 32'h5, 32'h99), 0);
        @(negedge clk);
        checkOutput("basicLatency", XLEN'(bus.outValid), XLEN'(1));
        idle(1);

        // Both sources match rs1: source 0 wins; then x0 reads as zero.
        bus.rs1Addr      = 5'd3;
        bus.fwdEnable    = 2'b11;
        bus.fwdRd        = {5'd3, 5'd3};
        bus.fwdData      = {32'hBB, 32'hAA};
        bus.fwdDataReady = 2'b11;
        applyStimulus(mkExp(32'hAA, 32'h5, 32'h99), 0);
        bus.rs1Addr = 5'd0;
        bus.fwdRd   = {5'd0, 5'd0};
        applyStimulus(mkExp(32'h0, 32'h5, 32'h99), 0);
        idle(2);

        // Load-use: youngest source pending, older ready source must not hide it.
        clearInputs();
        bus.rs2Addr      = 5'd7;
        bus.rs2Data      = 32'h1234;
        bus.input1Select = 2'b01;
        bus.pcValue      = 32'h200;
        bus.input2Select = 3'b000;
        bus.fwdEnable    = 2'b11;
        bus.fwdRd        = {5'd7, 5'd7};
        bus.fwdData      = {32'h77, 32'h42};
        bus.fwdDataReady = 2'b10;
        bus.inValid      = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("loadUseStall", XLEN'(bus.hazardStall), XLEN'(1));
            checkOutput("loadUseInReady", XLEN'(bus.inReady), '0);
        end
        @(posedge clk);
        #1;
        bus.fwdDataReady = 2'b11;
        applyStimulus(mkExp(32'h200, 32'h42, 32'h42), 0);

        // Pending rs2 is irrelevant when the immediate is selected and no store.
        bus.fwdDataReady   = 2'b10;
        bus.input2Select   = 3'b001;
        bus.immediateValue = 32'h33;
        bus.storeEnable    = 1'b0;
        applyStimulus(mkExp(32'h200, 32'h33, 32'h42), 0);

        // A store still needs rs2, so the same pending source stalls.
        bus.storeEnable = 1'b1;
        bus.inValid     = 1'b1;
        @(negedge clk);
        checkOutput("storeStall", XLEN'(bus.hazardStall), XLEN'(1));
        checkOutput("storeInReady", XLEN'(bus.inReady), '0);
        @(posedge clk);
        #1;
        bus.inValid = 1'b0;
        clearInputs();
        idle(2);

        // Backpressure: held bundle stays put while a new one waits.
        bus.outReady     = 1'b0;
        bus.rs1Addr      = 5'd4;
        bus.rs1Data      = 32'hA1;
        bus.rs2Addr      = 5'd5;
        bus.rs2Data      = 32'hA2;
        applyStimulus(mkExp(32'hA1, 32'hA2, 32'hA2), 0);
        bus.rs1Data = 32'hB1;
        bus.rs2Data = 32'hB2;
        bus.inValid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("bpInReady", XLEN'(bus.inReady), '0);
            checkOutput("bpOutValid", XLEN'(bus.outValid), XLEN'(1));
            checkOutput("bpHold1", bus.input1Alu, 32'hA1);
            checkOutput("bpHold2", bus.input2Alu, 32'hA2);
            checkOutput("bpHoldSt", bus.storeData, 32'hA2);
        end
        @(posedge clk);
        #1;
        bus.outReady = 1'b1;
        applyStimulus(mkExp(32'hB1, 32'hB2, 32'hB2), 0);
        bus.rs1Data = 32'hC1;
        bus.rs2Data = 32'hC2;
        applyStimulus(mkExp(32'hC1, 32'hC2, 32'hC2), 0);
        idle(2);

        // Flush kills a held bundle.
        bus.outReady = 1'b0;
        bus.rs1Data  = 32'hD1;
        bus.rs2Data  = 32'hD2;
        applyStimulus(mkExp(32'hD1, 32'hD2, 32'hD2), 0);
        bus.rs1Data = 32'hE1;
        bus.inValid = 1'b1;
        bus.flush   = 1'b1;
        @(posedge clk);
        #1;
        bus.flush   = 1'b0;
        bus.inValid = 1'b0;
        void'(expQ.pop_front());
        @(negedge clk);
        checkOutput("flushHeld", XLEN'(bus.outValid), '0);
        bus.outReady = 1'b1;
        idle(1);

        // Flush drops an input the block would otherwise have taken.
        bus.inValid = 1'b1;
        bus.flush   = 1'b1;
        @(negedge clk);
        checkOutput("flushInReady", XLEN'(bus.inReady), XLEN'(1));
        @(posedge clk);
        #1;
        bus.flush   = 1'b0;
        bus.inValid = 1'b0;
        @(negedge clk);
        checkOutput("flushDrop", XLEN'(bus.outValid), '0);
        idle(1);

        // Reset mid-stream clears valid and data, overriding a pending capture.
        bus.outReady = 1'b0;
        bus.rs1Data  = 32'hF1;
        bus.rs2Data  = 32'hF2;
        applyStimulus(mkExp(32'hF1, 32'hF2, 32'hF2), 0);
        bus.inValid = 1'b1;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        bus.inValid = 1'b0;
        void'(expQ.pop_front());
        @(negedge clk);
        checkOutput("midResetValid", XLEN'(bus.outValid), '0);
        checkOutput("midReset1", bus.input1Alu, '0);
        checkOutput("midReset2", bus.input2Alu, '0);
        checkOutput("midResetSt", bus.storeData, '0);
        clearInputs();
        idle(1);

        // Constants, PC, zero selects, and x0 as store data.
        bus.input1Select = 2'b01;
        bus.pcValue      = 32'h100;
        bus.rs2Addr      = 5'd0;
        bus.rs2Data      = 32'hDEAD;
        bus.input2Select = 3'b010;
        applyStimulus(mkExp(32'h100, 32'h1, 32'h0), 0);
        bus.input2Select = 3'b011;
        applyStimulus(mkExp(32'h100, 32'h4, 32'h0), 0);
        bus.input2Select = 3'b110;
        applyStimulus(mkExp(32'h100, 32'h0, 32'h0), 0);

        // Unused rs1 with a pending producer, zero selects: no stall.
        bus.input1Select = 2'b11;
        bus.rs1Addr      = 5'd9;
        bus.rs1Data      = 32'h55;
        bus.input2Select = 3'b111;
        bus.fwdEnable    = 2'b01;
        bus.fwdRd        = {5'd0, 5'd9};
        bus.fwdDataReady = 2'b10;
        applyStimulus(mkExp(32'h0, 32'h0, 32'h0), 0);
        bus.input1Select = 2'b10;
        bus.input2Select = 3'b101;
        applyStimulus(mkExp(32'h0, 32'h0, 32'h0), 0);

        idle(3);
        checkOutput("queueEmpty", XLEN'(expQ.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
